// File: rtl/comb_reverb_mixer.sv
// comb_reverb_mixer
//   Wet/dry mixer behind a bank of parallel comb filters. On each sample
//   strobe it captures every comb output plus the dry sample and both gains,
//   sums the comb outputs one channel per cycle with a single adder, then
//   applies the wet and dry gains through one shared multiplier, shifts back
//   to the fixed-point grid and saturates to the output word.
//
// Ports
//   clk           system clock
//   rstn          asynchronous active-low reset
//   sample_strobe one-cycle pulse: new sample present on the inputs
//   comb_in       packed signed comb outputs, channel i at [i*WORD +: WORD]
//   dry_in        signed dry sample
//   wet_gain      signed fixed-point wet gain
//   dry_gain      signed fixed-point dry gain
//   ovr_clr       clears the sticky overrun flag
//   out           signed mixed sample, held between updates
//   out_valid     one-cycle pulse when out updates
//   busy          high whenever a sample is being processed
//   overrun       sticky: a strobe arrived while busy
//
// FIXED_POINT (fraction bits) normally comes from constants.svh; a default
// is provided here so the block also builds stand-alone.
`ifndef FIXED_POINT
`define FIXED_POINT 16
`endif

module comb_reverb_mixer #(
    parameter  int WIDTH   = 24,
    parameter  int N_COMBS = 4,
    localparam int WORD    = WIDTH + `FIXED_POINT,
    localparam int ACC_W   = WORD + $clog2(N_COMBS) + 1
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      sample_strobe,
    input  logic [N_COMBS*WORD-1:0]   comb_in,
    input  logic [WORD-1:0]           dry_in,
    input  logic [WORD-1:0]           wet_gain,
    input  logic [WORD-1:0]           dry_gain,
    input  logic                      ovr_clr,
    output logic [WORD-1:0]           out,
    output logic                      out_valid,
    output logic                      busy,
    output logic                      overrun
);

    localparam int FP     = `FIXED_POINT;
    localparam int PROD_W = ACC_W + WORD;
    localparam int TOT_W  = PROD_W + 1;
    localparam int IDX_W  = (N_COMBS > 1) ? $clog2(N_COMBS) : 1;

    typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_WET, S_DRY, S_OUT} state_e;

    state_e                   state_q;
    logic signed [WORD-1:0]   comb_q [N_COMBS];
    logic signed [WORD-1:0]   dry_q;
    logic signed [WORD-1:0]   wet_gain_q;
    logic signed [WORD-1:0]   dry_gain_q;
    logic [IDX_W-1:0]         idx_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [PROD_W-1:0] prod_q;
    logic signed [TOT_W-1:0]  total_q;
    logic [WORD-1:0]          out_q;
    logic                     out_valid_q;
    logic                     overrun_q;

    logic signed [ACC_W-1:0]  comb_ext;
    logic signed [PROD_W-1:0] mul_a;
    logic signed [PROD_W-1:0] mul_b;
    logic signed [PROD_W-1:0] mul_p;
    logic signed [TOT_W-1:0]  shifted;
    logic                     fits;
    logic [WORD-1:0]          sat_val;

    always_comb begin
        comb_ext = {{(ACC_W-WORD){comb_q[idx_q][WORD-1]}}, comb_q[idx_q]};
        // One multiplier serves both gain stages: acc*wet in WET, dry*dry_gain
        // in DRY. Operands are pre-extended so the product is exact.
        if (state_q == S_WET) begin
            mul_a = {{(PROD_W-ACC_W){acc_q[ACC_W-1]}}, acc_q};
            mul_b = {{(PROD_W-WORD){wet_gain_q[WORD-1]}}, wet_gain_q};
        end else begin
            mul_a = {{(PROD_W-WORD){dry_q[WORD-1]}}, dry_q};
            mul_b = {{(PROD_W-WORD){dry_gain_q[WORD-1]}}, dry_gain_q};
        end
        mul_p   = mul_a * mul_b;
        shifted = total_q >>> FP;
        // Value fits the output word when all bits above the output sign bit
        // replicate it.
        fits    = (&shifted[TOT_W-1:WORD-1]) || ~(|shifted[TOT_W-1:WORD-1]);
        if (fits)
            sat_val = shifted[WORD-1:0];
        else if (shifted[TOT_W-1])
            sat_val = {1'b1, {(WORD-1){1'b0}}};
        else
            sat_val = {1'b0, {(WORD-1){1'b1}}};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            for (int unsigned i = 0; i < N_COMBS; i++) comb_q[i] <= '0;
            dry_q       <= '0;
            wet_gain_q  <= '0;
            dry_gain_q  <= '0;
            idx_q       <= '0;
            acc_q       <= '0;
            prod_q      <= '0;
            total_q     <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            // A strobe while busy sets the flag even if ovr_clr is also high.
            if (sample_strobe && (state_q != S_IDLE))
                overrun_q <= 1'b1;
            else if (ovr_clr)
                overrun_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (sample_strobe) begin
                        for (int unsigned i = 0; i < N_COMBS; i++)
                            comb_q[i] <= comb_in[i*WORD +: WORD];
                        dry_q      <= dry_in;
                        wet_gain_q <= wet_gain;
                        dry_gain_q <= dry_gain;
                        acc_q      <= '0;
                        idx_q      <= '0;
                        state_q    <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    acc_q <= acc_q + comb_ext;
                    idx_q <= idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(N_COMBS-1))
                        state_q <= S_WET;
                end
                S_WET: begin
                    prod_q  <= mul_p;
                    state_q <= S_DRY;
                end
                S_DRY: begin
                    total_q <= {prod_q[PROD_W-1], prod_q} + {mul_p[PROD_W-1], mul_p};
                    state_q <= S_OUT;
                end
                S_OUT: begin
                    out_q       <= sat_val;
                    out_valid_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != S_IDLE);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_comb_reverb_mixer.sv
// Testbench for comb_reverb_mixer: scoreboard of expected samples and output
// cycles, pushed at strobe time and popped on each out_valid pulse.
`ifndef FIXED_POINT
`define FIXED_POINT 16
`endif

module tb_comb_reverb_mixer;

    localparam int WIDTH = 24;
    localparam int N     = 4;
    localparam int FP    = `FIXED_POINT;
    localparam int WORD  = WIDTH + FP;

    logic                clk = 1'b0;
    logic                rstn = 1'b0;
    logic                sample_strobe = 1'b0;
    logic                ovr_clr = 1'b0;
    logic [N*WORD-1:0]   comb_in = '0;
    logic [WORD-1:0]     dry_in = '0;
    logic [WORD-1:0]     wet_gain = '0;
    logic [WORD-1:0]     dry_gain = '0;
    logic [WORD-1:0]     out;
    logic                out_valid;
    logic                busy;
    logic                overrun;

    comb_reverb_mixer #(.WIDTH(WIDTH), .N_COMBS(N)) dut (
        .clk(clk), .rstn(rstn), .sample_strobe(sample_strobe),
        .comb_in(comb_in), .dry_in(dry_in), .wet_gain(wet_gain),
        .dry_gain(dry_gain), .ovr_clr(ovr_clr), .out(out),
        .out_valid(out_valid), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [WORD-1:0] val;
        int              at;
    } exp_t;
    exp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [WORD-1:0] fx(input longint v);
        return WORD'(v);
    endfunction

    function automatic logic [N*WORD-1:0] pack4(input logic [WORD-1:0] c0, c1, c2, c3);
        return {c3, c2, c1, c0};
    endfunction

    // Reference: sum, x wet, + dry x dry_gain, >>> FP, saturate.
    function automatic logic [WORD-1:0] model(input logic [N*WORD-1:0] c,
                                              input logic [WORD-1:0] d, wg, dg);
        logic signed [127:0]    acc, tot, t, mx, mn;
        logic signed [WORD-1:0] w, ds, wgs, dgs;
        acc = 0;
        for (int i = 0; i < N; i++) begin
            w   = c[i*WORD +: WORD];
            acc = acc + w;
        end
        ds  = d;
        wgs = wg;
        dgs = dg;
        tot = acc * wgs + ds * dgs;
        t   = tot >>> FP;
        mx  = (128'sd1 <<< (WORD-1)) - 128'sd1;
        mn  = -(128'sd1 <<< (WORD-1));
        if (t > mx) t = mx;
        else if (t < mn) t = mn;
        return t[WORD-1:0];
    endfunction

    task automatic scramble();
        comb_in  = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        dry_in   = {$urandom(), $urandom()};
        wet_gain = {$urandom(), $urandom()};
        dry_gain = {$urandom(), $urandom()};
    endtask

    // Drive a one-cycle strobe; returns at the negedge after the sampling edge.
    task automatic strobe(input logic [N*WORD-1:0] c, input logic [WORD-1:0] d, wg, dg,
                          input bit accept, input logic [WORD-1:0] expv);
        @(negedge clk);
        comb_in = c; dry_in = d; wet_gain = wg; dry_gain = dg;
        sample_strobe = 1'b1;
        if (accept) sb.push_back('{expv, cyc + 8});
        @(negedge clk);
        sample_strobe = 1'b0;
        scramble();
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((sb.size() != 0 || busy) && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) chk("drain_timeout", 64'(sb.size()), 0);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            assert (!$isunknown(out)) else $error("out has unknown bits");
            if (out_valid) begin
                if (sb.size() == 0) chk("spurious_valid", 1, 0);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out", out, e.val);
                    chk("latency", 64'(cyc), 64'(e.at));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [N*WORD-1:0] basic_c, rc;
    logic [WORD-1:0]   maxw, minw, rd, rwg, rdg;
    logic signed [31:0] r;

    initial begin
        basic_c = pack4(fx(65536), fx(131072), fx(-32768), fx(32768));
        maxw    = {1'b0, {(WORD-1){1'b1}}};
        minw    = {1'b1, {(WORD-1){1'b0}}};

        // Reset held with activity on the inputs.
        rstn = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            scramble();
            sample_strobe = 1'($urandom());
            ovr_clr       = 1'($urandom());
            @(posedge clk);
            #1;
            chk("rst_out", out, 0);
            chk("rst_valid", out_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_ovr", overrun, 0);
        end
        @(negedge clk);
        sample_strobe = 1'b0;
        ovr_clr = 1'b0;
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_out", out, 0);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_ovr", overrun, 0);

        // Basic mix: 3.0*0.5 + 4.0*0.25 = 2.5
        strobe(basic_c, fx(262144), fx(32768), fx(16384), 1'b1, fx(163840));
        chk("busy_k", busy, 1);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            chk("busy_mid", busy, 1);
        end
        @(negedge clk);
        chk("busy_end", busy, 0);
        wait_idle();

        // Saturation
        strobe({N{maxw}}, fx(0), fx(65536), fx(0), 1'b1, maxw);
        wait_idle();
        strobe({N{minw}}, fx(0), fx(65536), fx(0), 1'b1, minw);
        wait_idle();
        strobe('0, fx(-131072), fx(65536), fx(-65536), 1'b1, fx(131072));
        wait_idle();

        // Overrun: second strobe 3 cycles after the first.
        chk("ovr_initial", overrun, 0);
        strobe(basic_c, fx(262144), fx(32768), fx(16384), 1'b1, fx(163840));
        @(negedge clk);
        @(negedge clk);
        sample_strobe = 1'b1;
        @(negedge clk);
        sample_strobe = 1'b0;
        chk("ovr_set", overrun, 1);
        wait_idle();
        chk("ovr_sticky", overrun, 1);
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        chk("ovr_clr", overrun, 0);

        // Set beats clear in the same busy cycle.
        strobe(basic_c, fx(262144), fx(32768), fx(16384), 1'b1, fx(163840));
        sample_strobe = 1'b1;
        ovr_clr = 1'b1;
        @(negedge clk);
        sample_strobe = 1'b0;
        ovr_clr = 1'b0;
        chk("ovr_set_wins", overrun, 1);
        wait_idle();
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        chk("ovr_clr2", overrun, 0);

        // Reset during ACCUM aborts the sample.
        strobe(basic_c, fx(262144), fx(32768), fx(16384), 1'b0, '0);
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        chk("abort_out", out, 0);
        chk("abort_busy", busy, 0);
        rstn = 1'b1;
        repeat (10) @(negedge clk);
        chk("abort_out_hold", out, 0);
        strobe(basic_c, fx(262144), fx(32768), fx(16384), 1'b1, fx(163840));
        wait_idle();

        // Back-to-back, spacing 8 cycles, random data.
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < N; j++) begin
                r = $urandom();
                if (i % 3 == 0) rc[j*WORD +: WORD] = {8'($urandom()), r};
                else            rc[j*WORD +: WORD] = WORD'(r);
            end
            r = $urandom(); rd  = WORD'(r >>> 8);
            r = $urandom(); rwg = WORD'(r >>> 14);
            r = $urandom(); rdg = WORD'(r >>> 14);
            strobe(rc, rd, rwg, rdg, 1'b1, model(rc, rd, rwg, rdg));
            repeat (6) @(negedge clk);
        end
        wait_idle();
        chk("b2b_ovr", overrun, 0);
        chk("sb_empty", 64'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
